gpio_in_capture: RTL and testbench

- Input-direction companion to the GPIO output write-enable decoder: captures two external input ports for the CPU's memory-mapped read path.
- Each port is synchronized, then debounced by a stability filter.
- Rising edges on the filtered value set sticky, write-1-to-clear status bits; `irq` is raised while any status bit is set.
- Sits between the external pins and the GPIO read mux; addressed by the same 2-bit word select.

---
 rtl/gpio_in_capture_if.sv | 14 +
 rtl/gpio_in_capture.sv | 94 +++++++++
 tb/tb_gpio_in_capture.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_in_capture_if.sv
// CPU-side word-select bus between the GPIO read mux and gpio_in_capture.
// The CPU drives A/WE/WD; the capture block returns RD and irq.
interface gpio_in_capture_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       A;
  logic             WE;
  logic [WIDTH-1:0] WD;
  logic [WIDTH-1:0] RD;
  logic             irq;

  modport master (output A, output WE, output WD, input RD, input irq);
  modport slave  (input A, input WE, input WD, output RD, output irq);
endinterface

// File: rtl/gpio_in_capture.sv
// Two-port GPIO input capture: 2-flop synchronizer, whole-word stability filter,
// sticky write-1-to-clear rising-edge status and a level interrupt.
module gpio_in_capture #(
  parameter int WIDTH     = 32,
  parameter int DB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  gpio_in_capture_if.slave    bus,
  input  logic [WIDTH-1:0]    gpI1,
  input  logic [WIDTH-1:0]    gpI2
);

  localparam logic [7:0] DB_C = 8'(DB_CYCLES);

  // Index 0 is port 1, index 1 is port 2.
  logic [1:0][WIDTH-1:0] s1_q, s2_q;
  logic [1:0][WIDTH-1:0] held_q, held_d;
  logic [1:0][7:0]       cnt_q, cnt_d;
  logic [1:0][WIDTH-1:0] filt_q, filt_d;
  logic [1:0][WIDTH-1:0] status_q, status_d;
  logic [1:0][WIDTH-1:0] rise_s, clr_s;
  logic [WIDTH-1:0]      rd_s;

  always_comb begin
    held_d   = held_q;
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    status_d = status_q;
    rise_s   = '0;
    clr_s    = '0;
    for (int p = 0; p < 2; p++) begin
      // Any movement of the synchronized word restarts qualification.
      if (s2_q[p] != held_q[p]) begin
        held_d[p] = s2_q[p];
        cnt_d[p]  = 8'd1;
      end else if (cnt_q[p] < DB_C) begin
        cnt_d[p]  = cnt_q[p] + 8'd1;
      end else begin
        cnt_d[p]  = cnt_q[p];
      end

      if ((cnt_q[p] == DB_C) && (held_q[p] != filt_q[p])) begin
        filt_d[p] = held_q[p];
        rise_s[p] = held_q[p] & ~filt_q[p];
      end else begin
        filt_d[p] = filt_q[p];
        rise_s[p] = '0;
      end

      if (bus.WE && bus.A[1] && (bus.A[0] == 1'(p))) begin
        clr_s[p] = bus.WD;
      end else begin
        clr_s[p] = '0;
      end

      // A rise on the same edge as a clear wins.
      status_d[p] = (status_q[p] & ~clr_s[p]) | rise_s[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      held_q   <= '0;
      cnt_q    <= '0;
      filt_q   <= '0;
      status_q <= '0;
    end else begin
      s1_q     <= {gpI2, gpI1};
      s2_q     <= s1_q;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rd_s = '0;
    case (bus.A)
      2'b00:   rd_s = filt_q[0];
      2'b01:   rd_s = filt_q[1];
      2'b10:   rd_s = status_q[0];
      2'b11:   rd_s = status_q[1];
      default: rd_s = '0;
    endcase
  end

  assign bus.RD  = rd_s;
  assign bus.irq = (|status_q[0]) | (|status_q[1]);

endmodule

// File: tb/tb_gpio_in_capture.sv
// Bench for gpio_in_capture: constant-expectation vector table, hand-written corner
// sequences, and randomized traffic checked against a sample-history reference model.
module tb_gpio_in_capture;

  localparam int W  = 32;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  gpI1 = '0;
  logic [W-1:0]  gpI2 = '0;

  gpio_in_capture_if #(.WIDTH(W)) bus ();

  gpio_in_capture #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .gpI1 (gpI1),
    .gpI2 (gpI2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a word is accepted once the same value has been sampled at the pin
  // on DB consecutive edges; it reaches filt 3 edges after its last qualifying sample.
  logic [W-1:0] hist1[$];
  logic [W-1:0] hist2[$];
  logic [W-1:0] m_filt [2];
  logic [W-1:0] m_stat [2];

  typedef struct {
    logic [1:0]   a;
    logic         we;
    logic [W-1:0] wd;
    logic [W-1:0] g1;
    logic [W-1:0] g2;
    int           ncyc;
    logic [W-1:0] exp_rd;
    logic         exp_irq;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    hist1.delete();
    hist2.delete();
    m_filt[0] = '0;
    m_filt[1] = '0;
    m_stat[0] = '0;
    m_stat[1] = '0;
  endfunction

  function automatic logic [W-1:0] m_rd(input logic [1:0] a);
    case (a)
      2'b00:   return m_filt[0];
      2'b01:   return m_filt[1];
      2'b10:   return m_stat[0];
      default: return m_stat[1];
    endcase
  endfunction

  function automatic void m_port(input int p, input logic [W-1:0] pin);
    logic [W-1:0] h[$];
    logic [W-1:0] v, rise, clr;
    logic ok;
    if (p == 0) h = hist1; else h = hist2;
    h.push_back(pin);
    if (h.size() > DB + 3) void'(h.pop_front());
    ok = (h.size() == DB + 3);
    v  = '0;
    if (ok) begin
      v = h[h.size() - 4];
      for (int k = 0; k < DB; k++) if (h[h.size() - 4 - k] != v) ok = 1'b0;
    end
    rise = '0;
    if (ok && (v != m_filt[p])) begin
      rise      = v & ~m_filt[p];
      m_filt[p] = v;
    end
    clr = (bus.WE && (bus.A == ((p == 0) ? 2'b10 : 2'b11))) ? bus.WD : '0;
    m_stat[p] = (m_stat[p] & ~clr) | rise;
    if (p == 0) hist1 = h; else hist2 = h;
  endfunction

  // One clock edge: advance the model on the inputs the DUT sees, then compare.
  task automatic tick();
    m_port(0, gpI1);
    m_port(1, gpI2);
    @(posedge clk);
    #1;
    check("rd_model", bus.RD, m_rd(bus.A));
    check("irq_model", {31'd0, bus.irq}, {31'd0, (|m_stat[0]) | (|m_stat[1])});
  endtask

  task automatic drive(input logic [1:0] a, input logic we, input logic [W-1:0] wd,
                       input logic [W-1:0] g1, input logic [W-1:0] g2);
    bus.A  = a;
    bus.WE = we;
    bus.WD = wd;
    gpI1   = g1;
    gpI2   = g2;
  endtask

  initial begin
    int hold;
    bus.A  = 2'b00;
    bus.WE = 1'b0;
    bus.WD = '0;
    m_reset();

    // a, we, wd, g1, g2, cycles, expected RD, expected irq
    tbl[0]  = '{2'b00, 1'b0, 32'h0,        32'h0,  32'h0, 1, 32'h0,        1'b0};
    tbl[1]  = '{2'b00, 1'b0, 32'h0,        32'hA5, 32'h0, 6, 32'h0,        1'b0};
    tbl[2]  = '{2'b00, 1'b0, 32'h0,        32'hA5, 32'h0, 1, 32'hA5,       1'b1};
    tbl[3]  = '{2'b10, 1'b0, 32'h0,        32'hA5, 32'h0, 1, 32'hA5,       1'b1};
    tbl[4]  = '{2'b10, 1'b1, 32'h05,       32'hA5, 32'h0, 1, 32'hA0,       1'b1};
    tbl[5]  = '{2'b10, 1'b1, 32'hA0,       32'hA5, 32'h0, 1, 32'h0,        1'b0};
    tbl[6]  = '{2'b00, 1'b0, 32'h0,        32'hA5, 32'h0, 1, 32'hA5,       1'b0};
    tbl[7]  = '{2'b01, 1'b0, 32'h0,        32'hA5, 32'h8, 3, 32'h0,        1'b0};
    tbl[8]  = '{2'b01, 1'b0, 32'h0,        32'hA5, 32'h0, 8, 32'h0,        1'b0};
    tbl[9]  = '{2'b11, 1'b0, 32'h0,        32'hA5, 32'h0, 1, 32'h0,        1'b0};
    tbl[10] = '{2'b11, 1'b0, 32'h0,        32'hA5, 32'h8, 4, 32'h0,        1'b0};
    tbl[11] = '{2'b11, 1'b0, 32'h0,        32'hA5, 32'h0, 2, 32'h0,        1'b0};
    tbl[12] = '{2'b11, 1'b0, 32'h0,        32'hA5, 32'h0, 1, 32'h8,        1'b1};
    tbl[13] = '{2'b11, 1'b1, 32'h8,        32'hA5, 32'h0, 1, 32'h0,        1'b0};
    tbl[14] = '{2'b00, 1'b0, 32'h0,        32'hFF, 32'h0, 7, 32'hFF,       1'b1};
    tbl[15] = '{2'b10, 1'b1, 32'hFFFFFFFF, 32'hFF, 32'h0, 1, 32'h0,        1'b0};
    tbl[16] = '{2'b00, 1'b0, 32'h0,        32'h0,  32'h0, 6, 32'hFF,       1'b0};
    tbl[17] = '{2'b00, 1'b0, 32'h0,        32'h0,  32'h0, 1, 32'h0,        1'b0};
    tbl[18] = '{2'b10, 1'b0, 32'h0,        32'h0,  32'h0, 1, 32'h0,        1'b0};

    // Reset state for every word select.
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.A = 2'(a);
      #1;
      check("reset_rd", bus.RD, 32'h0);
    end
    check("reset_irq", {31'd0, bus.irq}, 32'h0);
    bus.A = 2'b00;
    rst   = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].g1, tbl[i].g2);
      repeat (tbl[i].ncyc) tick();
      check($sformatf("vec%0d_rd", i), bus.RD, tbl[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, bus.irq}, {31'd0, tbl[i].exp_irq});
    end

    // Rise on bit 0 lands on the same edge as a clear of bit 0.
    drive(2'b10, 1'b0, 32'h0, 32'h1, 32'h0);
    repeat (6) tick();
    check("pre_rise_status1", bus.RD, 32'h0);
    drive(2'b10, 1'b1, 32'h1, 32'h1, 32'h0);
    tick();
    check("set_beats_clear", bus.RD, 32'h1);
    drive(2'b00, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0);
    tick();
    check("write_a00_filt1", bus.RD, 32'h1);
    drive(2'b01, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0);
    tick();
    drive(2'b10, 1'b0, 32'h0, 32'h1, 32'h0);
    #1;
    check("write_a0x_nochange", bus.RD, 32'h1);
    check("write_a0x_irq", {31'd0, bus.irq}, 32'h1);
    drive(2'b10, 1'b1, 32'h1, 32'h1, 32'h0);
    tick();
    check("clear_after_set", bus.RD, 32'h0);

    // Randomized traffic against the reference model.
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 7);
        if ($urandom_range(0, 1) == 0) gpI1 = $urandom();
        else gpI1 = gpI1 ^ (32'h1 << $urandom_range(0, 31));
        if ($urandom_range(0, 2) == 0) gpI2 = $urandom();
      end
      hold--;
      bus.A  = 2'($urandom_range(0, 3));
      bus.WE = ($urandom_range(0, 5) == 0);
      bus.WD = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom());
      tick();
    end

    // Reset in the middle of a pending qualification on port 2.
    drive(2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0);
    repeat (10) tick();
    drive(2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h55);
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.A = 2'(a);
      #1;
      check("midrst_rd", bus.RD, 32'h0);
    end
    check("midrst_irq", {31'd0, bus.irq}, 32'h0);
    m_reset();
    @(posedge clk);
    #2;
    rst   = 1'b0;
    bus.A = 2'b10;
    repeat (6) tick();
    check("requal_early_status1", bus.RD, 32'h0);
    check("requal_early_irq", {31'd0, bus.irq}, 32'h0);
    tick();
    check("requal_status1", bus.RD, 32'hFFFFFFFF);
    check("requal_irq", {31'd0, bus.irq}, 32'h1);
    bus.A = 2'b11;
    #1;
    check("requal_status2", bus.RD, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
